piezo_sched: RTL and testbench

//  Owns the single piezo output and shares it between three sound requesters: alarm clock
//  (trill), countdown timer (0.5 s beep) and hourly chime (N short beeps).

---
 rtl/piezo_pkg.sv | 32 +++
 rtl/piezo_tone_gen.sv | 80 ++++++++
 rtl/piezo_sched.sv | 114 +++++++++++
 tb/tb_piezo_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared encodings, scheduler state type and default timing for the piezo scheduler.
// The state encoding equals the active_src encoding so the state register drives the port directly.
package piezo_pkg;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_CHIME = 2'd1;
    localparam logic [1:0] SRC_TIMER = 2'd2;
    localparam logic [1:0] SRC_ALARM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = SRC_NONE,
        ST_CHIME = SRC_CHIME,
        ST_TIMER = SRC_TIMER,
        ST_ALARM = SRC_ALARM
    } state_t;

    localparam int DEF_TRILL_HALF   = 50;
    localparam int DEF_BEEP_PERIOD  = 1000;
    localparam int DEF_BEEP_ON      = 500;
    localparam int DEF_CHIME_PERIOD = 500;
    localparam int DEF_CHIME_ON     = 200;
    localparam int MAX_CHIMES       = 12;

    // A stroke count of 0 or above the maximum means a full hourly chime.
    function automatic logic [3:0] clamp_strokes(input logic [3:0] n);
        if (n == 4'd0 || n > 4'(MAX_CHIMES)) begin
            return 4'(MAX_CHIMES);
        end
        return n;
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Tone pattern generator: trill, timer beep and chime stroke waveforms.
// Dropping en_i clears every phase counter and silences the output for that cycle.
module piezo_tone_gen
    import piezo_pkg::*;
#(
    parameter int TRILL_HALF   = DEF_TRILL_HALF,
    parameter int BEEP_PERIOD  = DEF_BEEP_PERIOD,
    parameter int BEEP_ON      = DEF_BEEP_ON,
    parameter int CHIME_PERIOD = DEF_CHIME_PERIOD,
    parameter int CHIME_ON     = DEF_CHIME_ON
) (
    input  logic   clk,
    input  logic   rst,
    input  state_t pat_i,
    input  logic   en_i,
    output logic   piezo_o,
    output logic   stroke_end_o
);

    localparam int TW = (TRILL_HALF > 1)   ? $clog2(TRILL_HALF)   : 1;
    localparam int BW = (BEEP_PERIOD > 1)  ? $clog2(BEEP_PERIOD)  : 1;
    localparam int SW = (CHIME_PERIOD > 1) ? $clog2(CHIME_PERIOD) : 1;

    logic [TW-1:0] trill_cnt_q, trill_cnt_d;
    logic          tone_b_q, tone_b_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic [SW-1:0] stroke_cnt_q, stroke_cnt_d;
    logic          piezo_q, piezo_d;

    always_comb begin
        trill_cnt_d  = '0;
        tone_b_d     = 1'b0;
        beep_cnt_d   = '0;
        stroke_cnt_d = '0;
        piezo_d      = 1'b0;
        if (en_i) begin
            case (pat_i)
                ST_ALARM: begin
                    tone_b_d    = tone_b_q;
                    trill_cnt_d = trill_cnt_q + 1'b1;
                    // Tone B halves the toggle rate by toggling only on even phase counts.
                    piezo_d = (!tone_b_q || !trill_cnt_q[0]) ? ~piezo_q : piezo_q;
                    if (trill_cnt_q == TW'(TRILL_HALF - 1)) begin
                        trill_cnt_d = '0;
                        tone_b_d    = ~tone_b_q;
                    end
                end
                ST_TIMER: begin
                    beep_cnt_d = (beep_cnt_q == BW'(BEEP_PERIOD - 1)) ? '0 : beep_cnt_q + 1'b1;
                    piezo_d    = (beep_cnt_q < BW'(BEEP_ON)) ? ~piezo_q : 1'b0;
                end
                ST_CHIME: begin
                    stroke_cnt_d = (stroke_cnt_q == SW'(CHIME_PERIOD - 1)) ? '0 : stroke_cnt_q + 1'b1;
                    piezo_d      = (stroke_cnt_q < SW'(CHIME_ON)) ? ~piezo_q : 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            trill_cnt_q  <= '0;
            tone_b_q     <= 1'b0;
            beep_cnt_q   <= '0;
            stroke_cnt_q <= '0;
            piezo_q      <= 1'b0;
        end else begin
            trill_cnt_q  <= trill_cnt_d;
            tone_b_q     <= tone_b_d;
            beep_cnt_q   <= beep_cnt_d;
            stroke_cnt_q <= stroke_cnt_d;
            piezo_q      <= piezo_d;
        end
    end

    assign piezo_o      = piezo_q;
    assign stroke_end_o = (stroke_cnt_q == SW'(CHIME_PERIOD - 1));

endmodule

// File: rtl/piezo_sched.sv
// Fixed-priority piezo owner (ALARM > TIMER > CHIME) with per-source mute
// and suspend/resume bookkeeping for the hourly chime.
module piezo_sched
    import piezo_pkg::*;
#(
    parameter int TRILL_HALF   = DEF_TRILL_HALF,
    parameter int BEEP_PERIOD  = DEF_BEEP_PERIOD,
    parameter int BEEP_ON      = DEF_BEEP_ON,
    parameter int CHIME_PERIOD = DEF_CHIME_PERIOD,
    parameter int CHIME_ON     = DEF_CHIME_ON
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_req,
    input  logic       timer_req,
    input  logic       chime_start,
    input  logic [3:0] chime_count,
    input  logic       mute_p,
    output logic       piezo,
    output logic [1:0] active_src,
    output logic       busy,
    output logic       chime_done
);

    state_t     state_q, state_d;
    logic       alarm_mute_q, alarm_mute_d;
    logic       timer_mute_q, timer_mute_d;
    logic       chime_pend_q, chime_pend_d;
    logic [3:0] strokes_q, strokes_d;
    logic       chime_done_q, chime_done_d;
    logic       chime_restart;
    logic       tone_en;
    logic       stroke_end_raw;
    logic       stroke_end;

    assign stroke_end = (state_q == ST_CHIME) && stroke_end_raw;

    // Next-state uses the already-updated flags so a mute or a finished chime
    // takes effect on the same edge rather than one cycle later.
    always_comb begin
        alarm_mute_d  = alarm_req & (alarm_mute_q | (mute_p & (state_q == ST_ALARM)));
        timer_mute_d  = timer_req & (timer_mute_q | (mute_p & (state_q == ST_TIMER)));
        chime_pend_d  = chime_pend_q;
        strokes_d     = strokes_q;
        chime_done_d  = 1'b0;
        chime_restart = 1'b0;

        if (chime_start) begin
            chime_pend_d  = 1'b1;
            strokes_d     = clamp_strokes(chime_count);
            chime_restart = (state_q == ST_CHIME);
        end else if (mute_p && state_q == ST_CHIME) begin
            chime_pend_d = 1'b0;
        end else if (stroke_end) begin
            if (strokes_q <= 4'd1) begin
                chime_pend_d = 1'b0;
                strokes_d    = 4'd0;
                chime_done_d = 1'b1;
            end else begin
                strokes_d = strokes_q - 4'd1;
            end
        end

        if (alarm_req && !alarm_mute_d) begin
            state_d = ST_ALARM;
        end else if (timer_req && !timer_mute_d) begin
            state_d = ST_TIMER;
        end else if (chime_pend_d) begin
            state_d = ST_CHIME;
        end else begin
            state_d = ST_IDLE;
        end

        tone_en = (state_d == state_q) && !chime_restart;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            alarm_mute_q <= 1'b0;
            timer_mute_q <= 1'b0;
            chime_pend_q <= 1'b0;
            strokes_q    <= 4'd0;
            chime_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_mute_q <= alarm_mute_d;
            timer_mute_q <= timer_mute_d;
            chime_pend_q <= chime_pend_d;
            strokes_q    <= strokes_d;
            chime_done_q <= chime_done_d;
        end
    end

    piezo_tone_gen #(
        .TRILL_HALF  (TRILL_HALF),
        .BEEP_PERIOD (BEEP_PERIOD),
        .BEEP_ON     (BEEP_ON),
        .CHIME_PERIOD(CHIME_PERIOD),
        .CHIME_ON    (CHIME_ON)
    ) u_tone (
        .clk         (clk),
        .rst         (rst),
        .pat_i       (state_d),
        .en_i        (tone_en),
        .piezo_o     (piezo),
        .stroke_end_o(stroke_end_raw)
    );

    assign active_src = state_q;
    assign busy       = (state_q != ST_IDLE);
    assign chime_done = chime_done_q;

endmodule

// File: tb/tb_piezo_sched.sv
// Directed bench for piezo_sched: priority, tone shapes, mute, chime suspend/resume and reset.
module tb_piezo_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       alarm_req;
    logic       timer_req;
    logic       chime_start;
    logic [3:0] chime_count;
    logic       mute_p;
    logic       piezo;
    logic [1:0] active_src;
    logic       busy;
    logic       chime_done;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    piezo_sched dut (
        .clk        (clk),
        .rst        (rst),
        .alarm_req  (alarm_req),
        .timer_req  (timer_req),
        .chime_start(chime_start),
        .chime_count(chime_count),
        .mute_p     (mute_p),
        .piezo      (piezo),
        .active_src (active_src),
        .busy       (busy),
        .chime_done (chime_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected piezo i edges into a chime (i starts at 1): 200 toggles then silence per 500.
    function automatic logic stroke_exp(input int i);
        int p;
        p = (i - 1) % 500;
        return (p < 200) ? logic'((p + 1) & 1) : 1'b0;
    endfunction

    initial begin
        rst = 1'b0; alarm_req = 1'b0; timer_req = 1'b0;
        chime_start = 1'b0; chime_count = 4'd0; mute_p = 1'b0;

        // Reset state
        step(); step();
        chk("rst_piezo", piezo, 0);
        chk("rst_src", active_src, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", chime_done, 0);
        rst = 1'b1;
        step();
        chk("idle_src", active_src, 0);

        // Alarm trill: tone A 50 toggles, tone B toggles every 2nd edge
        alarm_req = 1'b1;
        step();
        chk("alarm_src", active_src, 3);
        chk("alarm_entry_piezo", piezo, 0);
        chk("alarm_busy", busy, 1);
        for (int i = 1; i <= 50; i++) begin
            step();
            chk("trill_a", piezo, i & 1);
        end
        for (int i = 1; i <= 50; i++) begin
            step();
            chk("trill_b", piezo, ((i + 1) / 2) & 1);
        end
        step();
        chk("trill_a_again", piezo, 0);
        alarm_req = 1'b0;
        step();
        chk("alarm_rel_src", active_src, 0);
        chk("alarm_rel_piezo", piezo, 0);

        // Timer beep: 500 toggles, 500 silent, repeat; then mute
        timer_req = 1'b1;
        step();
        chk("timer_src", active_src, 2);
        chk("timer_entry_piezo", piezo, 0);
        for (int i = 1; i <= 1000; i++) begin
            step();
            chk("beep", piezo, (i <= 500) ? (i & 1) : 0);
        end
        step();
        chk("beep_repeat", piezo, 1);
        mute_p = 1'b1;
        step();
        mute_p = 1'b0;
        chk("timer_mute_piezo", piezo, 0);
        chk("timer_mute_busy", busy, 0);
        step(); step();
        chk("timer_mute_holds", active_src, 0);
        timer_req = 1'b0;
        step();
        timer_req = 1'b1;
        step();
        chk("timer_rearm_src", active_src, 2);
        step();
        chk("timer_rearm_piezo", piezo, 1);
        timer_req = 1'b0;
        step();
        chk("timer_drop_src", active_src, 0);

        // Chime count=3: three strokes, done at edge 1500
        chime_count = 4'd3; chime_start = 1'b1;
        step();
        chime_start = 1'b0;
        chk("chime_src", active_src, 1);
        chk("chime_entry_piezo", piezo, 0);
        for (int i = 1; i <= 1500; i++) begin
            step();
            chk("chime3_piezo", piezo, stroke_exp(i));
            chk("chime3_done", chime_done, (i == 1500) ? 1 : 0);
            chk("chime3_src", active_src, (i < 1500) ? 1 : 0);
        end
        step();
        chk("chime3_done_pulse", chime_done, 0);

        // Chime count=0 clamps to 12 strokes, done at edge 6000
        chime_count = 4'd0; chime_start = 1'b1;
        step();
        chime_start = 1'b0;
        for (int i = 1; i <= 6000; i++) begin
            step();
            chk("chime12_done", chime_done, (i == 6000) ? 1 : 0);
        end
        chk("chime12_src", active_src, 0);

        // Chime count=5 preempted by alarm after stroke 2
        chime_count = 4'd5; chime_start = 1'b1;
        step();
        chime_start = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            chk("pre_piezo", piezo, stroke_exp(i));
            chk("pre_done", chime_done, 0);
        end
        alarm_req = 1'b1;
        step();
        chk("preempt_src", active_src, 3);
        chk("preempt_piezo", piezo, 0);
        for (int i = 1; i <= 299; i++) begin
            step();
            chk("preempt_hold_src", active_src, 3);
            chk("preempt_no_done", chime_done, 0);
            if (i <= 50) chk("preempt_trill", piezo, i & 1);
        end
        alarm_req = 1'b0;
        step();
        chk("resume_src", active_src, 1);
        chk("resume_piezo", piezo, 0);
        for (int i = 1; i <= 1500; i++) begin
            step();
            chk("resume_piezo", piezo, stroke_exp(i));
            chk("resume_done", chime_done, (i == 1500) ? 1 : 0);
        end
        step();
        chk("resume_idle", active_src, 0);

        // Alarm + timer, mute alarm -> timer from beep_cnt 0
        alarm_req = 1'b1; timer_req = 1'b1;
        step();
        chk("both_src", active_src, 3);
        for (int i = 0; i < 5; i++) step();
        mute_p = 1'b1;
        step();
        mute_p = 1'b0;
        chk("mute_alarm_src", active_src, 2);
        chk("mute_alarm_piezo", piezo, 0);
        step();
        chk("beep_cnt0_a", piezo, 1);
        step();
        chk("beep_cnt0_b", piezo, 0);
        // mute_p with a higher request rising: timer muted, alarm plays
        alarm_req = 1'b0;
        step();
        chk("alarm_drop_src", active_src, 2);
        mute_p = 1'b1; alarm_req = 1'b1;
        step();
        mute_p = 1'b0;
        chk("mute_plus_rise_src", active_src, 3);
        alarm_req = 1'b0;
        step();
        chk("timer_stays_muted", active_src, 0);
        timer_req = 1'b0;
        step();

        // chime_start coinciding with the final stroke end: reload, no done
        chime_count = 4'd1; chime_start = 1'b1;
        step();
        chime_start = 1'b0;
        for (int i = 1; i <= 499; i++) step();
        chime_start = 1'b1;
        step();
        chime_start = 1'b0;
        chk("restart_no_done", chime_done, 0);
        chk("restart_src", active_src, 1);
        chk("restart_piezo", piezo, 0);
        for (int i = 1; i <= 500; i++) begin
            step();
            chk("restart_piezo", piezo, stroke_exp(i));
            chk("restart_done", chime_done, (i == 500) ? 1 : 0);
        end

        // Mute during chime: drop it without chime_done
        chime_count = 4'd3; chime_start = 1'b1;
        step();
        chime_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        mute_p = 1'b1;
        step();
        mute_p = 1'b0;
        chk("chime_mute_src", active_src, 0);
        chk("chime_mute_done", chime_done, 0);
        step();
        chk("chime_mute_stays", active_src, 0);

        // Reset mid-stroke
        chime_count = 4'd2; chime_start = 1'b1;
        step();
        chime_start = 1'b0;
        for (int i = 1; i <= 51; i++) step();
        chk("mid_stroke_piezo", piezo, 1);
        rst = 1'b0;
        step();
        chk("midrst_piezo", piezo, 0);
        chk("midrst_src", active_src, 0);
        chk("midrst_done", chime_done, 0);
        rst = 1'b1;
        for (int i = 1; i <= 1200; i++) begin
            step();
            chk("postrst_src", active_src, 0);
            chk("postrst_done", chime_done, 0);
            chk("postrst_piezo", piezo, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
